// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the multiplexed display path.
package bcd_disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'hF;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [1:0] digit_idx_t;
  typedef logic [3:0] bcd_t;

  // Active-low one-cold anode pattern for a digit position.
  function automatic logic [NUM_DIGITS-1:0] an_select(digit_idx_t idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running prescaler: counts 0..TICK_DIV-1 and pulses tick on the terminal count.
module scan_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [$clog2(TICK_DIV)-1:0] cnt,
  output logic                        tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(TICK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/bcd_scan_mux.sv
// 4-digit BCD scan controller with tear-free frame-boundary commit,
// leading-zero / invalid-digit blanking and anti-ghost guard cycles.
module bcd_scan_mux
  import bcd_disp_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned GUARD    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  bcd_out,
  output logic        blank_out,
  output logic [3:0]  an,
  output logic        frame_done,
  output logic        load_ack,
  output logic        err
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt;
  logic             tick;

  scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (cnt),
    .tick  (tick)
  );

  digit_idx_t  idx_q, idx_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_v_q, pend_v_d;
  logic [15:0] disp_q, disp_d;
  logic        ack_pend_q, ack_pend_d;
  logic [3:0]  an_q, an_d;
  bcd_t        bcd_q, bcd_d;
  logic        blank_q, blank_d;
  logic        frame_done_q, frame_done_d;
  logic        load_ack_q, load_ack_d;
  logic        err_q, err_d;

  logic frame_edge, commit, lz_hit;
  bcd_t cur;

  always_comb begin
    frame_edge = tick && (idx_q == 2'd3);
    commit     = frame_edge && pend_v_q;

    idx_d  = tick ? idx_q + 2'd1 : idx_q;
    disp_d = commit ? pend_q : disp_q;
    pend_d = load ? digits_in : pend_q;
    // A load on the boundary edge re-arms pend_v, deferring it to the next frame.
    if (load)        pend_v_d = 1'b1;
    else if (commit) pend_v_d = 1'b0;
    else             pend_v_d = pend_v_q;

    cur    = disp_q[{idx_q, 2'b00} +: 4];
    lz_hit = blank_lz && (idx_q != 2'd0) && ((disp_q >> {idx_q, 2'b00}) == '0);

    an_d    = AN_OFF;
    blank_d = 1'b1;
    bcd_d   = cur;
    err_d   = err_q;
    if (cnt < CNT_W'(GUARD)) begin
      an_d = AN_OFF;
    end else if (cur > BCD_MAX) begin
      an_d  = an_select(idx_q);
      err_d = 1'b1;
    end else if (!lz_hit) begin
      an_d    = an_select(idx_q);
      blank_d = 1'b0;
    end

    frame_done_d = frame_edge;
    ack_pend_d   = commit;
    load_ack_d   = ack_pend_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      disp_q       <= '0;
      ack_pend_q   <= 1'b0;
      an_q         <= AN_OFF;
      bcd_q        <= '0;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
      load_ack_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      disp_q       <= disp_d;
      ack_pend_q   <= ack_pend_d;
      an_q         <= an_d;
      bcd_q        <= bcd_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
      load_ack_q   <= load_ack_d;
      err_q        <= err_d;
    end
  end

  assign an         = an_q;
  assign bcd_out    = bcd_q;
  assign blank_out  = blank_q;
  assign frame_done = frame_done_q;
  assign load_ack   = load_ack_q;
  assign err        = err_q;

endmodule

// File: tb/tb_bcd_scan_mux.sv
// Scoreboard bench for bcd_scan_mux: a cycle-count reference model queues expected
// outputs, a negedge monitor pops and compares them.
module tb_bcd_scan_mux;

  localparam int unsigned TD = 4;
  localparam int unsigned GD = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  bcd_out;
  logic        blank_out;
  logic [3:0]  an;
  logic        frame_done;
  logic        load_ack;
  logic        err;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] bcd;
    logic       blank;
    logic       fd;
    logic       ack;
    logic       err;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ack_seen = 0;

  always #5 clk = ~clk;

  bcd_scan_mux #(.TICK_DIV(TD), .GUARD(GD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_in  (digits_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .bcd_out    (bcd_out),
    .blank_out  (blank_out),
    .an         (an),
    .frame_done (frame_done),
    .load_ack   (load_ack),
    .err        (err)
  );

  // Reference model: position in the frame comes purely from the number of
  // clock edges since reset; m_k is the cycle whose state the outputs reflect.
  initial begin : model
    int unsigned m_k, phase, slot;
    logic [15:0] m_disp, m_pend;
    bit          m_pv, m_err, m_ack_next, bnd;
    logic [3:0]  d;
    obs_t        e;
    m_k = 0; m_disp = '0; m_pend = '0; m_pv = 0; m_err = 0; m_ack_next = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_k = 0; m_disp = '0; m_pend = '0; m_pv = 0; m_err = 0; m_ack_next = 0;
      end else begin
        phase = m_k % TD;
        slot  = (m_k / TD) % 4;
        d     = 4'(m_disp >> (4 * slot));
        e.bcd   = d;
        e.an    = 4'hF;
        e.blank = 1'b1;
        if (phase >= GD) begin
          if (d > 4'd9) begin
            e.an  = ~(4'b0001 << slot);
            m_err = 1;
          end else if (!(blank_lz && slot != 0 && (m_disp >> (4 * slot)) == 16'h0)) begin
            e.an    = ~(4'b0001 << slot);
            e.blank = 1'b0;
          end
        end
        e.err = m_err;
        bnd   = (m_k % (4 * TD)) == (4 * TD - 1);
        e.fd  = bnd;
        e.ack = m_ack_next;
        m_ack_next = bnd && m_pv;
        if (bnd && m_pv) begin
          m_disp = m_pend;
          m_pv   = 0;
        end
        if (load) begin
          m_pend = digits_in;
          m_pv   = 1;
        end
        m_k++;
        exp_q.push_back(e);
      end
    end
  end

  initial begin : monitor
    obs_t e, got;
    forever begin
      @(negedge clk);
      got = '{an: an, bcd: bcd_out, blank: blank_out, fd: frame_done, ack: load_ack, err: err};
      if (!rst_n) begin
        exp_q.delete();
        checks++;
        if (got !== obs_t'{an: 4'hF, bcd: 4'h0, blank: 1'b1, fd: 1'b0, ack: 1'b0, err: 1'b0}) begin
          errors++;
          $display("FAIL reset_state t=%0t got an=%h bcd=%h blank=%b fd=%b ack=%b err=%b want an=f bcd=0 blank=1 fd=0 ack=0 err=0",
                   $time, got.an, got.bcd, got.blank, got.fd, got.ack, got.err);
        end
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (load_ack === 1'b1) ack_seen++;
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t got an=%h bcd=%h blank=%b fd=%b ack=%b err=%b want an=%h bcd=%h blank=%b fd=%b ack=%b err=%b",
                   $time, got.an, got.bcd, got.blank, got.fd, got.ack, got.err,
                   e.an, e.bcd, e.blank, e.fd, e.ack, e.err);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    @(negedge clk);
    digits_in = v;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL frame_done_timeout got frame_done=%b want 1 within 40 cycles", frame_done);
    end
  endtask

  initial begin : stimulus
    int a0;
    logic [15:0] v;
    idle(3);
    #2 rst_n = 1'b1;

    // Basic load and scan
    do_load(16'h1234);
    idle(40);

    // Leading-zero blanking
    blank_lz = 1'b1;
    do_load(16'h0050);
    idle(36);
    do_load(16'h0000);
    idle(36);
    blank_lz = 1'b0;

    // Two loads inside one frame give a single ack
    wait_fd();
    a0 = ack_seen;
    idle(2);
    do_load(16'h1111);
    idle(2);
    do_load(16'h2222);
    idle(40);
    checks++;
    if (ack_seen - a0 != 1) begin
      errors++;
      $display("FAIL double_load_ack got %0d acks want 1", ack_seen - a0);
    end

    // Load coinciding with the frame boundary edge
    wait_fd();
    idle(14);
    do_load(16'h5678);
    idle(40);

    // Invalid digit and sticky err
    do_load(16'h00A0);
    idle(36);
    do_load(16'h0000);
    idle(36);

    // Randomized loads and blanking
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        for (int n = 0; n < 4; n++)
          v[4*n +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                                      : 4'($urandom_range(0, 9));
        if ($urandom_range(0, 1) == 1) v = v & 16'h00FF;
        do_load(v);
      end
    end

    // Asynchronous reset mid-slot 2 with a pending load
    blank_lz = 1'b0;
    wait_fd();
    do_load(16'h4321);
    idle(7);
    a0 = ack_seen;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'hF || blank_out !== 1'b1 || load_ack !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got an=%h blank=%b ack=%b want an=f blank=1 ack=0", an, blank_out, load_ack);
    end
    idle(3);
    #2 rst_n = 1'b1;
    idle(40);
    checks++;
    if (ack_seen != a0) begin
      errors++;
      $display("FAIL reset_discards_pend got %0d acks want 0", ack_seen - a0);
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_scan_mux.md
# bcd_scan_mux

Time-multiplexed 4-digit scan controller that sits directly upstream of the existing BCD-to-7-segment decoder on the board display path. It holds a 4-digit BCD value and presents one digit at a time on `bcd_out`, with the matching active-low anode on `an`. Updates are tear-free: a new value is captured on `load` and committed only at a frame boundary. It also provides leading-zero blanking, invalid-digit blanking, and anti-ghosting guard cycles.

## Interface
- `TICK_DIV`, default 50000: clock cycles per digit slot. Legal range is 2..2^20, and it must exceed `GUARD`.
- `GUARD`, default 2: cycles at the start of each slot during which all anodes are off. Legal range is 0..`TICK_DIV`-1.
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `digits_in`  in  16  BCD value. `[3:0]` is digit 0 (rightmost, `an[0]`) and `[15:12]` is digit 3.
- `load`  in  1  single-cycle request; `digits_in` is captured into the pending register on this edge.
- `blank_lz`  in  1  leading-zero blanking enable; sampled every cycle.
- `bcd_out`  out  4  digit nibble for the decoder.
- `blank_out`  out  1  1 means the decoder must drive all segments off.
- `an`  out  4  anodes, active-low, at most one bit low at a time.
- `frame_done`  out  1  one-cycle pulse on the last cycle of the digit-3 slot.
- `load_ack`  out  1  one-cycle pulse on the first cycle after a pending value is committed.
- `err`  out  1  sticky flag; set when a committed digit is greater than 9.

## Operation
- The prescaler `cnt` counts 0..`TICK_DIV`-1 and wraps. The wrap is the slot boundary.
- The digit index `idx` advances 0→1→2→3→0 at each slot boundary.
- Registers:
  - `pend` (16 bits) with `pend_v`: capture register and its valid bit.
  - `disp` (16 bits): the value being displayed.
- When `load` is high, `pend` takes `digits_in` and `pend_v` is set. A second `load` before commit overwrites `pend`; only the last value is shown, and only one `load_ack` is issued.
- Commit happens at the frame boundary (idx 3→0 edge) when `pend_v` is set:
  - `disp` takes `pend` and `pend_v` clears.
  - `load_ack` pulses in the first cycle of the new digit-0 slot.
- A `load` in the same cycle as a frame boundary goes to `pend` and is committed at the following boundary, not the current one.
- Output selection for slot `idx`, where `d` is nibble `idx` of `disp`:
  - Guard phase (`cnt` < `GUARD`): `an` = 4'hF, `blank_out` = 1.
  - `d` > 9: `an` bit low, `blank_out` = 1, `err` is set.
  - Leading-zero blanked: `an` = 4'hF, `blank_out` = 1. This applies when `blank_lz`=1, `idx` ≥ 1, and `disp` nibbles `idx`..3 are all zero. Digit 0 is never blanked by this rule.
  - Otherwise: `an` = ~(1<<`idx`), `blank_out` = 0, `bcd_out` = `d`.
- `bcd_out` always carries `d`, including when blanked.
- `err` clears only on reset.

## Timing
- All outputs are registered, giving 1-cycle latency from (`cnt`, `idx`, `disp`) to outputs.
- Reset values:
  - `cnt`=0, `idx`=0, `disp`=0, `pend`=0, `pend_v`=0.
  - `an`=4'hF, `bcd_out`=0, `blank_out`=1, `frame_done`=0, `load_ack`=0, `err`=0.
- The first rising edge with `rst_n` high begins slot 0.
- A slot lasts exactly `TICK_DIV` cycles; a frame lasts 4×`TICK_DIV` cycles.
- Per slot, `an` is off for `GUARD` cycles and on for `TICK_DIV`-`GUARD` cycles.
- `frame_done` and the commit edge coincide. `load_ack` follows 1 cycle later.
- Worst-case `load`→`load_ack` latency is 4×`TICK_DIV`+1 cycles.
- Reset asserted mid-frame forces all reset values immediately (asynchronously) and discards `pend`; no `load_ack` is issued.

## Structure
- Package `bcd_disp_pkg` holds:
  - `NUM_DIGITS`=4 and `AN_OFF`=4'hF.
  - `BCD_MAX`=4'd9.
  - Typedef `digit_idx_t` (2 bits) and typedef `bcd_t` (4 bits).
- Sub-module `scan_tick_gen`:
  - Parameter `TICK_DIV`.
  - Outputs `cnt` and a `tick` pulse on the terminal count.
  - Reused by the other display blocks.
- The decoder stays external; this block does not decode segments.

## Test plan
All scenarios use `TICK_DIV`=4 and `GUARD`=1.
- Reset then `load` of 16'h1234:
  - `load_ack` arrives exactly one cycle after the first `frame_done`.
  - The next frame shows an = E,D,B,7 with bcd_out = 4,3,2,1.
  - Each slot has one leading cycle of an=F.
- `blank_lz`=1, `disp`=16'h0050: digits 3 and 2 have an=F and blank_out=1; digits 1 and 0 show 5 and 0. With 16'h0000 only digit 0 lights, showing 0.
- Two `load`s (16'h1111 then 16'h2222) inside one frame: a single `load_ack`, and only 2222 is ever displayed.
- `load` on the `frame_done` cycle: the value is not committed at that boundary; `load_ack` follows the next `frame_done`.
- `load` of 16'h00A0: in slot 1, an=D and blank_out=1; `err` rises and stays 1 after reloading 16'h0000.
- `rst_n` pulsed low mid-slot 2 with a pending load: an=F and blank_out=1 immediately, no `load_ack`, and `disp`=0 after release.
